// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the register file with issue scoreboard.
package regfile_scoreboard_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  // Register 0 is hard-wired to zero and can never be busy
  localparam int REG_ZERO = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bundle of read, write, issue and status signals around the register file.
interface regfile_scoreboard_if
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT
);
  localparam int AW = $clog2(NREGS);

  logic            clr_req;
  logic            ready;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            we;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic [AW:0]     pend_cnt;

  modport master (
    output clr_req, rs1_addr, rs2_addr, we, rd_addr, rd_data, iss_valid, iss_rd,
    input  ready, rs1_data, rs2_data, rs1_busy, rs2_busy, pend_cnt
  );

  modport slave (
    input  clr_req, rs1_addr, rs2_addr, we, rd_addr, rd_data, iss_valid, iss_rd,
    output ready, rs1_data, rs2_data, rs1_busy, rs2_busy, pend_cnt
  );

endinterface

// File: rtl/regfile_sb_array.sv
// Register storage: two asynchronous read ports, one synchronous write port,
// register 0 always reads zero and ignores writes. Contents are not reset;
// the owner zeroes them by walking the addresses.
module regfile_sb_array
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            wen,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [XLEN-1:0] mem [NREGS];

  // Commit a write on the rising edge, never touching register 0
  always_ff @(posedge clk) begin
    if (wen && (waddr != ZERO_ADDR)) begin
      mem[waddr] <= wdata;
    end
  end

  // Read both ports straight from the array with register 0 forced to zero
  always_comb begin
    rdata1 = (raddr1 == ZERO_ADDR) ? '0 : mem[raddr1];
    rdata2 = (raddr2 == ZERO_ADDR) ? '0 : mem[raddr2];
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard, pending counter,
// optional write-to-read forwarding and a clear walk that zeroes the array.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int BYPASS = 1
) (
  input logic                 clk,
  input logic                 rst,
  regfile_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] ZERO_ADDR  = AW'(REG_ZERO);
  localparam logic [AW-1:0] FIRST_ADDR = AW'(1);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(NREGS - 1);

  state_t          state, state_nxt;
  logic [AW-1:0]   idx, idx_nxt;
  logic [NREGS-1:0] busy, busy_nxt;
  logic [AW:0]     pend, pend_nxt;

  logic            ready_int;
  logic            wr_fire, iss_fire;
  logic            byp1, byp2;
  logic            arr_we;
  logic [AW-1:0]   arr_waddr;
  logic [XLEN-1:0] arr_wdata;
  logic [XLEN-1:0] arr_rdata1, arr_rdata2;

  regfile_sb_array #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_array (
    .clk    (clk),
    .wen    (arr_we),
    .waddr  (arr_waddr),
    .wdata  (arr_wdata),
    .raddr1 (bus.rs1_addr),
    .raddr2 (bus.rs2_addr),
    .rdata1 (arr_rdata1),
    .rdata2 (arr_rdata2)
  );

  // Clear-walk state and index; reset always restarts the walk at register 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      idx   <= FIRST_ADDR;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Advance the walk one register per cycle; a clear request restarts it
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      CLEAR: begin
        if (bus.clr_req) begin
          idx_nxt = FIRST_ADDR;
        end else if (idx == LAST_ADDR) begin
          state_nxt = READY;
          idx_nxt   = FIRST_ADDR;
        end else begin
          idx_nxt = idx + FIRST_ADDR;
        end
      end
      READY: begin
        if (bus.clr_req) begin
          state_nxt = CLEAR;
          idx_nxt   = FIRST_ADDR;
        end
      end
      default: begin
        state_nxt = CLEAR;
        idx_nxt   = FIRST_ADDR;
      end
    endcase
  end

  // Steer the array write port: zeroes during the walk, user writes when ready
  always_comb begin
    ready_int = 1'b0;
    arr_we    = 1'b0;
    arr_waddr = idx;
    arr_wdata = '0;
    case (state)
      CLEAR: begin
        arr_we = 1'b1;
      end
      READY: begin
        ready_int = 1'b1;
        arr_we    = bus.we && (bus.rd_addr != ZERO_ADDR);
        arr_waddr = bus.rd_addr;
        arr_wdata = bus.rd_data;
      end
      default: begin
        ready_int = 1'b0;
      end
    endcase
  end

  // Qualify writes and issues; writes and issues to register 0 are dropped
  always_comb begin
    wr_fire  = ready_int && bus.we && (bus.rd_addr != ZERO_ADDR);
    iss_fire = ready_int && bus.iss_valid && (bus.iss_rd != ZERO_ADDR);
  end

  // Next busy bits and their population count; an issue overrides a same-cycle write
  always_comb begin
    busy_nxt = busy;
    if (ready_int && bus.clr_req) begin
      busy_nxt = '0;
    end else begin
      if (wr_fire) busy_nxt[bus.rd_addr] = 1'b0;
      if (iss_fire) busy_nxt[bus.iss_rd] = 1'b1;
    end
    busy_nxt[REG_ZERO] = 1'b0;
    pend_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      pend_nxt = pend_nxt + (AW+1)'(busy_nxt[i]);
    end
  end

  // Scoreboard bits and counter update together so they always agree
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      pend <= '0;
    end else begin
      busy <= busy_nxt;
      pend <= pend_nxt;
    end
  end

  // Read outputs with optional forwarding of the in-flight write
  always_comb begin
    byp1 = (BYPASS != 0) && wr_fire && (bus.rs1_addr == bus.rd_addr);
    byp2 = (BYPASS != 0) && wr_fire && (bus.rs2_addr == bus.rd_addr);
    bus.ready    = ready_int;
    bus.pend_cnt = pend;
    bus.rs1_data = !ready_int ? '0 : (byp1 ? bus.rd_data : arr_rdata1);
    bus.rs2_data = !ready_int ? '0 : (byp2 ? bus.rd_data : arr_rdata2);
    bus.rs1_busy = busy[bus.rs1_addr] && !byp1;
    bus.rs2_busy = busy[bus.rs2_addr] && !byp2;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: one forwarding and one non-forwarding instance driven
// identically; expected read data is queued from a reference model.
module tb_regfile_scoreboard;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [XLEN-1:0] model [NREGS];
  logic [XLEN-1:0] exp_q [$];

  regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();
  regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS)) bus_nb ();

  assign bus_nb.clr_req   = bus.clr_req;
  assign bus_nb.rs1_addr  = bus.rs1_addr;
  assign bus_nb.rs2_addr  = bus.rs2_addr;
  assign bus_nb.we        = bus.we;
  assign bus_nb.rd_addr   = bus.rd_addr;
  assign bus_nb.rd_data   = bus.rd_data;
  assign bus_nb.iss_valid = bus.iss_valid;
  assign bus_nb.iss_rd    = bus.iss_rd;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (bus_nb)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck design still ends the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle_inputs();
    bus.clr_req   = 1'b0;
    bus.we        = 1'b0;
    bus.rd_addr   = '0;
    bus.rd_data   = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NREGS; i++) model[i] = '0;
  endtask

  task automatic push_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    bus.rs1_addr = a1;
    bus.rs2_addr = a2;
    exp_q.push_back(model[a1]);
    exp_q.push_back(model[a2]);
  endtask

  task automatic test_reset();
    int n;
    logic [XLEN-1:0] exp;
    idle_inputs();
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;
    rst = 1'b1;
    repeat (2) next_cycle();
    n_checks++;
    if (bus.ready !== 1'b0) $display("[TB] FAIL reset_ready: got %b expected 0", bus.ready);
    else n_pass++;
    n_checks++;
    if (bus.pend_cnt !== '0) $display("[TB] FAIL reset_pend: got %0d expected 0", bus.pend_cnt);
    else n_pass++;
    rst = 1'b0;
    n = 0;
    while (bus.ready !== 1'b1 && n < 200) begin
      next_cycle();
      n++;
    end
    n_checks++;
    if (n != 31) $display("[TB] FAIL reset_walk_len: got %0d cycles expected 31", n);
    else n_pass++;
    clear_model();
    for (int i = 0; i < NREGS; i++) begin
      push_read(AW'(i), AW'(NREGS - 1 - i));
      #1;
      exp = exp_q.pop_front();
      n_checks++;
      if (bus.rs1_data !== exp) $display("[TB] FAIL readback_rs1 x%0d: got %h expected %h", i, bus.rs1_data, exp);
      else n_pass++;
      exp = exp_q.pop_front();
      n_checks++;
      if (bus.rs2_data !== exp) $display("[TB] FAIL readback_rs2 x%0d: got %h expected %h", NREGS - 1 - i, bus.rs2_data, exp);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] exp;
    bus.we       = 1'b1;
    bus.rd_addr  = 5'd5;
    bus.rd_data  = 32'hDEADBEEF;
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd0;
    #1;
    n_checks++;
    if (bus.rs1_data !== 32'hDEADBEEF) $display("[TB] FAIL bypass_fwd: got %h expected deadbeef", bus.rs1_data);
    else n_pass++;
    n_checks++;
    if (bus_nb.rs1_data !== model[5]) $display("[TB] FAIL bypass_none: got %h expected %h", bus_nb.rs1_data, model[5]);
    else n_pass++;
    model[5] = 32'hDEADBEEF;
    next_cycle();
    idle_inputs();
    push_read(5'd5, 5'd5);
    #1;
    exp = exp_q.pop_front();
    n_checks++;
    if (bus.rs1_data !== exp) $display("[TB] FAIL bypass_after_fwd: got %h expected %h", bus.rs1_data, exp);
    else n_pass++;
    exp = exp_q.pop_front();
    n_checks++;
    if (bus_nb.rs2_data !== exp) $display("[TB] FAIL bypass_after_none: got %h expected %h", bus_nb.rs2_data, exp);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_x0();
    bus.we        = 1'b1;
    bus.rd_addr   = 5'd0;
    bus.rd_data   = 32'hFFFFFFFF;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd0;
    bus.rs1_addr  = 5'd0;
    #1;
    n_checks++;
    if (bus.rs1_data !== '0) $display("[TB] FAIL x0_fwd_data: got %h expected 0", bus.rs1_data);
    else n_pass++;
    next_cycle();
    idle_inputs();
    #1;
    n_checks++;
    if (bus.rs1_data !== '0) $display("[TB] FAIL x0_data: got %h expected 0", bus.rs1_data);
    else n_pass++;
    n_checks++;
    if (bus.rs1_busy !== 1'b0) $display("[TB] FAIL x0_busy: got %b expected 0", bus.rs1_busy);
    else n_pass++;
    n_checks++;
    if (bus.pend_cnt !== '0) $display("[TB] FAIL x0_pend: got %0d expected 0", bus.pend_cnt);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_issue_retire();
    logic [XLEN-1:0] exp;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd3;
    next_cycle();
    n_checks++;
    if (bus.pend_cnt !== 6'd1) $display("[TB] FAIL pend_after_x3: got %0d expected 1", bus.pend_cnt);
    else n_pass++;
    bus.iss_rd = 5'd7;
    next_cycle();
    idle_inputs();
    bus.rs1_addr = 5'd3;
    #1;
    n_checks++;
    if (bus.pend_cnt !== 6'd2) $display("[TB] FAIL pend_after_x7: got %0d expected 2", bus.pend_cnt);
    else n_pass++;
    n_checks++;
    if (bus.rs1_busy !== 1'b1) $display("[TB] FAIL busy_x3_set: got %b expected 1", bus.rs1_busy);
    else n_pass++;
    bus.we      = 1'b1;
    bus.rd_addr = 5'd3;
    bus.rd_data = 32'h00000033;
    #1;
    n_checks++;
    if (bus.rs1_busy !== 1'b0) $display("[TB] FAIL busy_x3_masked: got %b expected 0", bus.rs1_busy);
    else n_pass++;
    n_checks++;
    if (bus_nb.rs1_busy !== 1'b1) $display("[TB] FAIL busy_x3_unmasked: got %b expected 1", bus_nb.rs1_busy);
    else n_pass++;
    model[3] = 32'h00000033;
    next_cycle();
    idle_inputs();
    #1;
    n_checks++;
    if (bus.pend_cnt !== 6'd1) $display("[TB] FAIL pend_after_wr_x3: got %0d expected 1", bus.pend_cnt);
    else n_pass++;
    n_checks++;
    if (bus_nb.rs1_busy !== 1'b0) $display("[TB] FAIL busy_x3_cleared: got %b expected 0", bus_nb.rs1_busy);
    else n_pass++;
    bus.we        = 1'b1;
    bus.rd_addr   = 5'd7;
    bus.rd_data   = 32'h77777777;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd7;
    model[7] = 32'h77777777;
    next_cycle();
    idle_inputs();
    push_read(5'd3, 5'd7);
    #1;
    n_checks++;
    if (bus.rs2_busy !== 1'b1) $display("[TB] FAIL busy_x7_issue_wins: got %b expected 1", bus.rs2_busy);
    else n_pass++;
    n_checks++;
    if (bus.pend_cnt !== 6'd1) $display("[TB] FAIL pend_issue_wins: got %0d expected 1", bus.pend_cnt);
    else n_pass++;
    exp = exp_q.pop_front();
    n_checks++;
    if (bus.rs1_data !== exp) $display("[TB] FAIL data_x3: got %h expected %h", bus.rs1_data, exp);
    else n_pass++;
    exp = exp_q.pop_front();
    n_checks++;
    if (bus.rs2_data !== exp) $display("[TB] FAIL data_x7: got %h expected %h", bus.rs2_data, exp);
    else n_pass++;
    bus.we      = 1'b1;
    bus.rd_addr = 5'd7;
    bus.rd_data = 32'h77777777;
    next_cycle();
    idle_inputs();
    n_checks++;
    if (bus.pend_cnt !== '0) $display("[TB] FAIL pend_drained: got %0d expected 0", bus.pend_cnt);
    else n_pass++;
  endtask

  task automatic test_clear();
    int n_low;
    logic [XLEN-1:0] exp;
    bus.we        = 1'b1;
    bus.rd_addr   = 5'd9;
    bus.rd_data   = 32'h12345678;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd9;
    model[9] = 32'h12345678;
    next_cycle();
    idle_inputs();
    push_read(5'd9, 5'd5);
    #1;
    n_checks++;
    if (bus.rs1_busy !== 1'b1 || bus.pend_cnt !== 6'd1)
      $display("[TB] FAIL pre_clear_busy: got busy %b pend %0d expected busy 1 pend 1", bus.rs1_busy, bus.pend_cnt);
    else n_pass++;
    exp = exp_q.pop_front();
    n_checks++;
    if (bus.rs1_data !== exp) $display("[TB] FAIL pre_clear_x9: got %h expected %h", bus.rs1_data, exp);
    else n_pass++;
    void'(exp_q.pop_front());
    bus.clr_req = 1'b1;
    n_low = 0;
    for (int k = 0; k < 200; k++) begin
      next_cycle();
      bus.clr_req = 1'b0;
      if (bus.ready === 1'b1) break;
      n_low++;
      if (n_low == 1) begin
        #1;
        n_checks++;
        if (bus.pend_cnt !== '0 || bus.rs1_busy !== 1'b0 || bus.rs1_data !== '0)
          $display("[TB] FAIL in_clear_status: got pend %0d busy %b data %h expected 0 0 0", bus.pend_cnt, bus.rs1_busy, bus.rs1_data);
        else n_pass++;
      end
    end
    n_checks++;
    if (n_low != 31) $display("[TB] FAIL clear_len: got %0d cycles expected 31", n_low);
    else n_pass++;
    clear_model();
    push_read(5'd9, 5'd5);
    #1;
    exp = exp_q.pop_front();
    n_checks++;
    if (bus.rs1_data !== exp || bus.rs1_busy !== 1'b0)
      $display("[TB] FAIL post_clear_x9: got %h busy %b expected %h busy 0", bus.rs1_data, bus.rs1_busy, exp);
    else n_pass++;
    exp = exp_q.pop_front();
    n_checks++;
    if (bus.rs2_data !== exp) $display("[TB] FAIL post_clear_x5: got %h expected %h", bus.rs2_data, exp);
    else n_pass++;
    bus.clr_req = 1'b1;
    n_low = 0;
    for (int k = 0; k < 200; k++) begin
      next_cycle();
      bus.clr_req = 1'b0;
      if (bus.ready === 1'b1) break;
      n_low++;
      if (n_low == 10) bus.clr_req = 1'b1;
    end
    n_checks++;
    if (n_low != 41) $display("[TB] FAIL clear_restart_len: got %0d cycles expected 41", n_low);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int n;
    logic [XLEN-1:0] exp;
    bus.clr_req = 1'b1;
    next_cycle();
    bus.clr_req = 1'b0;
    repeat (19) next_cycle();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.ready !== 1'b0 || bus.pend_cnt !== '0)
      $display("[TB] FAIL async_rst_clear: got ready %b pend %0d expected 0 0", bus.ready, bus.pend_cnt);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (bus.ready !== 1'b1 && n < 200) begin
      next_cycle();
      n++;
    end
    n_checks++;
    if (n != 31) $display("[TB] FAIL rst_mid_clear_len: got %0d cycles expected 31", n);
    else n_pass++;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd4;
    next_cycle();
    idle_inputs();
    bus.rs1_addr = 5'd4;
    #1;
    n_checks++;
    if (bus.ready !== 1'b1 || bus.pend_cnt !== 6'd1 || bus.rs1_busy !== 1'b1)
      $display("[TB] FAIL pre_rst_ready: got ready %b pend %0d busy %b expected 1 1 1", bus.ready, bus.pend_cnt, bus.rs1_busy);
    else n_pass++;
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.ready !== 1'b0) $display("[TB] FAIL async_rst_ready: got %b expected 0", bus.ready);
    else n_pass++;
    n_checks++;
    if (bus.pend_cnt !== '0) $display("[TB] FAIL async_rst_pend: got %0d expected 0", bus.pend_cnt);
    else n_pass++;
    n_checks++;
    if (bus.rs1_busy !== 1'b0) $display("[TB] FAIL async_rst_busy: got %b expected 0", bus.rs1_busy);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (bus.ready !== 1'b1 && n < 200) begin
      next_cycle();
      n++;
    end
    n_checks++;
    if (n != 31) $display("[TB] FAIL rst_mid_ready_len: got %0d cycles expected 31", n);
    else n_pass++;
    clear_model();
    push_read(5'd4, 5'd9);
    #1;
    exp = exp_q.pop_front();
    n_checks++;
    if (bus.rs1_data !== exp || bus.rs1_busy !== 1'b0)
      $display("[TB] FAIL post_rst_x4: got %h busy %b expected %h busy 0", bus.rs1_data, bus.rs1_busy, exp);
    else n_pass++;
    void'(exp_q.pop_front());
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_bypass();
    test_x0();
    test_issue_retire();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREGS, default 32, register count (power of two, >=4); AW = log2(NREGS).
REQ-003 Parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 clr_req  in  1  pulse; request zeroing of all registers.
REQ-007 ready  out  1  high when the file accepts writes and issues.
REQ-008 rs1_addr, rs2_addr  in  AW  read addresses.
REQ-009 rs1_data, rs2_data  out  XLEN  read data, combinational.
REQ-010 rs1_busy, rs2_busy  out  1  source register has a pending write.
REQ-011 we  in  1  write enable; rd_addr  in  AW; rd_data  in  XLEN.
REQ-012 iss_valid  in  1  instruction issued with destination; iss_rd  in  AW  its destination.
REQ-013 pend_cnt  out  AW+1  number of registers currently busy.

Function
REQ-014 Register 0 SHALL read as zero, never be written, never be busy.
REQ-015 Reads SHALL be combinational from the array; with BYPASS=1, ready, we=1, rd_addr=rsN_addr!=0, rsN_data SHALL equal rd_data.
REQ-016 While ready=0, rs1_data and rs2_data SHALL be zero.
REQ-017 With ready=1, a write with we=1 and rd_addr!=0 SHALL update the array at the next edge.
REQ-018 Each register SHALL have one busy bit: set at the edge after iss_valid=1 with iss_rd!=0; cleared at the edge after a write to it.
REQ-019 Issue and write to the same register in one cycle SHALL leave busy set (issue wins).
REQ-020 rsN_busy SHALL be the busy bit, masked to 0 when BYPASS=1 and that register is being written this cycle.
REQ-021 pend_cnt SHALL equal the popcount of the busy bits, registered, updated the same edge as the bits.
REQ-022 Clear FSM states: CLEAR, READY.
REQ-023 In CLEAR, an index starting at 1 SHALL write zero to one register per cycle; after index NREGS-1 is written, next state READY; ready=1 only in READY.
REQ-024 CLEAR SHALL take exactly NREGS-1 cycles.
REQ-025 clr_req in READY SHALL enter CLEAR at the next edge, index=1, all busy bits cleared.
REQ-026 clr_req during CLEAR SHALL restart the index at 1.
REQ-027 we and iss_valid SHALL be ignored while ready=0.

Reset
REQ-028 Asserting rst SHALL immediately force: state=CLEAR, index=1, all busy bits 0, pend_cnt=0, ready=0.
REQ-029 Array contents SHALL NOT be reset directly; the CLEAR walk zeroes them after rst deasserts.
REQ-030 rst asserted mid-CLEAR or mid-operation SHALL behave identically to REQ-028.

Structure
REQ-031 Shared package: XLEN/NREGS defaults, FSM state enum, register-0 address constant.
REQ-032 One sub-module, regfile_sb_array: storage, two async read ports, one sync write port, x0 masking.
REQ-033 FSM, scoreboard, counter and bypass SHALL live in the top module.

Verification
REQ-034 Release rst -> ready low 31 cycles (NREGS=32), then high; reading every register returns 0x00000000.
REQ-035 Write x5=0xDEADBEEF with rs1_addr=5 same cycle -> rs1_data=0xDEADBEEF (BYPASS=1), 0 (BYPASS=0); next cycle 0xDEADBEEF in both.
REQ-036 Write x0=0xFFFFFFFF, issue x0 -> rs1_data=0, rs1_busy=0, pend_cnt=0.
REQ-037 Issue x3, x7 on consecutive cycles -> pend_cnt 1 then 2; write x3 -> pend_cnt=1, rs busy(3)=0; issue and write x7 together -> busy(7) stays 1.
REQ-038 clr_req after writing x9=0x12345678 with x9 busy -> ready low 31 cycles, busy cleared, x9 reads 0; clr_req repeated at cycle 10 of CLEAR -> ready low until 31 cycles after it.
REQ-039 Assert rst asynchronously mid-CLEAR and mid-READY -> ready, pend_cnt, busy drop to 0 without waiting for a clock edge.
